// File: rtl/fp_pkg.sv
// Shared FP32 field widths, special exponent value and the normalizer FSM state type.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter for a 24-bit vector; an all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] a,
  output logic [4:0]  count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (a[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Normalizes an unnormalized sign/exp/mantissa result and packs it as an FP32 word.
// state | meaning
// IDLE  | ready for an operand (in_ready = 1)
// NORM  | special-case detection or one left-shift step per cycle
// DONE  | packed result held on out until out_ready (out_valid = 1)
module fp_norm_pack
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  state_t      state;
  logic        sign_r;
  logic [8:0]  exp_r;
  logic [24:0] mant_r;
  logic [31:0] out_r;

  logic [4:0]  lz;
  logic [4:0]  shift;
  logic [8:0]  exp_inc;
  logic [8:0]  exp_dec;

  fp_lzc24 u_lzc (
    .a     (mant_r[23:0]),
    .count (lz)
  );

  // Exponent math stays 9 bits wide so +1 and -shift cannot wrap unnoticed.
  always_comb begin
    shift   = (lz > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : lz;
    exp_inc = exp_r + 9'd1;
    exp_dec = exp_r - {4'b0, shift};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      exp_r  <= '0;
      mant_r <= '0;
      out_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= {1'b0, in_exp};
            mant_r <= in_mant;
            state  <= NORM;
          end
        end
        NORM: begin
          if (exp_r == {1'b0, EXP_MAX}) begin
            out_r <= pack_fp(sign_r, EXP_MAX, '0);
            state <= DONE;
          end else if (mant_r == '0 || exp_r == '0) begin
            out_r <= pack_fp(sign_r, '0, '0);
            state <= DONE;
          end else if (mant_r[24]) begin
            if (exp_inc >= {1'b0, EXP_MAX})
              out_r <= pack_fp(sign_r, EXP_MAX, '0);
            else
              out_r <= pack_fp(sign_r, exp_inc[7:0], mant_r[23:1]);
            state <= DONE;
          end else if (mant_r[23]) begin
            out_r <= pack_fp(sign_r, exp_r[7:0], mant_r[22:0]);
            state <= DONE;
          end else if (exp_r <= {4'b0, shift}) begin
            // Would land at or below exponent zero: flush, no subnormals.
            out_r <= pack_fp(sign_r, '0, '0);
            state <= DONE;
          end else begin
            exp_r  <= exp_dec;
            mant_r <= mant_r << shift;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_r;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed bench for fp_norm_pack: packing rules, multi-cycle normalization, backpressure, reset.
module tb_fp_norm_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  fp_norm_pack #(.MAX_SHIFT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one operand at a negedge; the following posedge is the handshake (cycle 0).
  task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m);
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called in cycle 1; returns the cycle in which out_valid is first seen, or -1.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc > 60) begin
        cyc = -1;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 00000000", out); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    drive(1'b0, 8'd127, 25'h0800000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL one_cycle: got %0d expected 2", cyc); end
    checks++;
    if (out !== 32'h3F800000) begin errors++; $display("FAIL one_out: got %h expected 3F800000", out); end
    consume();

    drive(1'b0, 8'd127, 25'h1000000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL carry_cycle: got %0d expected 2", cyc); end
    checks++;
    if (out !== 32'h40000000) begin errors++; $display("FAIL carry_out: got %h expected 40000000", out); end
    consume();

    drive(1'b0, 8'd254, 25'h1000000);
    wait_valid(cyc);
    checks++;
    if (out !== 32'h7F800000) begin errors++; $display("FAIL carry_ovf_out: got %h expected 7F800000", out); end
    consume();

    drive(1'b1, 8'hFF, 25'h0C00000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL inf_cycle: got %0d expected 2", cyc); end
    checks++;
    if (out !== 32'hFF800000) begin errors++; $display("FAIL inf_out: got %h expected FF800000", out); end
    consume();
  endtask

  task automatic test_normalize();
    int cyc;
    drive(1'b0, 8'd127, 25'h0000001);
    wait_valid(cyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL lz23_cycle: got %0d expected 8", cyc); end
    checks++;
    if (out !== 32'h34000000) begin errors++; $display("FAIL lz23_out: got %h expected 34000000", out); end
    consume();

    drive(1'b0, 8'd130, 25'h0018000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4) begin errors++; $display("FAIL lz7_cycle: got %0d expected 4", cyc); end
    checks++;
    if (out !== 32'h3DC00000) begin errors++; $display("FAIL lz7_out: got %h expected 3DC00000", out); end
    consume();
  endtask

  task automatic test_flush();
    int cyc;
    drive(1'b1, 8'd3, 25'h0000100);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL underflow_cycle: got %0d expected 2", cyc); end
    checks++;
    if (out !== 32'h80000000) begin errors++; $display("FAIL underflow_out: got %h expected 80000000", out); end
    consume();

    drive(1'b1, 8'd50, 25'h0000000);
    wait_valid(cyc);
    checks++;
    if (out !== 32'h80000000) begin errors++; $display("FAIL zero_mant_out: got %h expected 80000000", out); end
    consume();

    drive(1'b0, 8'd0, 25'h0800000);
    wait_valid(cyc);
    checks++;
    if (out !== 32'h00000000) begin errors++; $display("FAIL zero_exp_out: got %h expected 00000000", out); end
    consume();

    // exp 5 > shift 4 takes one step, then exp 1 <= 4 flushes.
    drive(1'b0, 8'd5, 25'h0000100);
    wait_valid(cyc);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL late_flush_cycle: got %0d expected 3", cyc); end
    checks++;
    if (out !== 32'h00000000) begin errors++; $display("FAIL late_flush_out: got %h expected 00000000", out); end
    consume();
  endtask

  task automatic test_backpressure();
    int cyc;
    drive(1'b0, 8'd127, 25'h0800000);
    wait_valid(cyc);
    in_sign  = 1'b1;
    in_exp   = 8'd10;
    in_mant  = 25'h1FFFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out !== 32'h3F800000 || out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b expected 3F800000/1", i, out, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_consume_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_after_consume: got %b/%b expected 1/0", in_ready, out_valid); end

    drive(1'b0, 8'd128, 25'h0800000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2 || out !== 32'h40000000)
      begin errors++; $display("FAIL bp_next: got %0d/%h expected 2/40000000", cyc, out); end
    consume();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    drive(1'b0, 8'd127, 25'h0000001);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out !== 32'h0)
      begin errors++; $display("FAIL rst_mid_out: got %b/%h expected 0/00000000", out_valid, out); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d valid cycles expected 0", seen); end

    drive(1'b0, 8'd127, 25'h0800000);
    wait_valid(cyc);
    checks++;
    if (cyc !== 2 || out !== 32'h3F800000)
      begin errors++; $display("FAIL rst_mid_next: got %0d/%h expected 2/3F800000", cyc, out); end
    consume();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_normalize();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_pack.md
FP_NORM_PACK -- requirements
Module: fp_norm_pack

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 4, meaning the maximum left-normalization shift per cycle (legal values 1..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1: an operand is presented.
REQ-005 SHALL have port in_ready, output, 1: the block accepts an operand this cycle.
REQ-006 SHALL have port in_sign, input, 1: result sign.
REQ-007 SHALL have port in_exp, input, 8: biased exponent of the unnormalized result.
REQ-008 SHALL have port in_mant, input, 25: bit 24 = carry-out, bit 23 = hidden bit, bits 22:0 = fraction.
REQ-009 SHALL have port out_valid, output, 1: packed result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out, output, 32: IEEE-754 single {sign, exp[7:0], mant[22:0]}.

Function
REQ-012 SHALL have FSM states IDLE, NORM and DONE; in_ready = 1 iff state == IDLE; out_valid = 1 iff state == DONE.
REQ-013 SHALL, in IDLE with in_valid = 1 (handshake, cycle 0), register sign/exp/mant and enter NORM in cycle 1; one operand in flight, no overlap.
REQ-014 SHALL, in NORM, apply exactly one of these rules per cycle, in priority order (a)-(e):
  (a) in_exp == 8'hFF: pack {sign, 8'hFF, 23'b0} (infinity); go to DONE.
  (b) mant == 0 or exp == 0: pack {sign, 31'b0} (signed zero, no subnormals); go to DONE.
  (c) mant[24] = 1: exp+1; if exp+1 == 255, pack infinity; else pack {sign, exp+1, mant[23:1]} (truncate, no rounding); go to DONE.
  (d) mant[23] = 1: pack {sign, exp, mant[22:0]}; go to DONE.
  (e) otherwise, s = min(leading zeros of mant[23:0], MAX_SHIFT): if exp <= s, pack signed zero and go to DONE; else exp -= s, mant <<= s, stay in NORM.
REQ-015 SHALL have latency, with MAX_SHIFT = 4:
  - out_valid first high in cycle 2 + ceil(lz/4), where lz = leading zeros of mant[23:0] at accept.
  - Cases (a)-(d) give cycle 2.
REQ-016 SHALL register out and hold it stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL, in DONE with out_ready = 1, return to IDLE next cycle; in_ready is therefore 0 during that handshake cycle.
REQ-018 SHALL ignore in_* ports when state != IDLE.
REQ-019 SHALL do all exponent arithmetic at 9 bits so that exp+1 and exp-s never wrap silently.

Reset
REQ-020 SHALL, on reset = 1 at a clock edge, set state = IDLE, out_valid = 0, out = 32'h0 and internal registers = 0.
REQ-021 SHALL, on reset mid-NORM or mid-DONE, discard the in-flight operand without emitting it; in_ready = 1 in the first cycle after reset deasserts.
REQ-022 SHALL give reset priority over simultaneous in_valid or out_ready.

Structure
REQ-023 SHALL put the following in shared package fp_pkg:
  - FP32 field widths (EXP_W = 8, MANT_W = 23).
  - EXP_MAX = 8'hFF.
  - The FSM state enum type.
REQ-024 SHALL place leading-zero counting in sub-module fp_lzc24 (24-bit input, 5-bit count, count = 24 for zero input).
REQ-025 SHALL keep shift, exponent update and packing in fp_norm_pack.

Verification
REQ-026 SHALL show: sign 0, exp 127, mant 0x0800000 -> out 0x3F800000, out_valid in cycle 2.
REQ-027 SHALL show:
  - exp 127, mant 0x1000000 -> 0x40000000 in cycle 2.
  - exp 254, mant 0x1000000 -> 0x7F800000.
REQ-028 SHALL show: exp 127, mant 0x0000001 (lz 23) -> 0x34000000, out_valid in cycle 8.
REQ-029 SHALL show: sign 1, exp 3, mant 0x0000100 -> flush to 0x80000000; sign 1, mant 0 -> 0x80000000.
REQ-030 SHALL show: out_ready held 0 for 3 cycles -> out stable, in_ready 0, in_valid ignored; then consumed, next operand accepted.
REQ-031 SHALL show: reset asserted during NORM of the lz-23 case -> no out_valid, in_ready 1 the cycle after reset drops, next operand correct.
